// File: rtl/cpu_pkg.sv
// Shared encodings for the softcore CPU: sequencer states and opcode classes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_LB,
    C_SB,
    C_JMPADR,
    C_JMPI,
    C_BR
  } op_class_e;

  // LB/SB/JMPADR are identified by the top four opcode bits; the lsb is a variant.
  localparam logic [3:0] OP_LB      = 4'b1001;
  localparam logic [3:0] OP_SB      = 4'b1010;
  localparam logic [3:0] OP_JMPADR  = 4'b1011;
  localparam logic [4:0] OP_JMPI    = 5'b11000;
  localparam logic [4:0] OP_BR_BASE = 5'b11001;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    if (op[4:1] == OP_LB)          cls = C_LB;
    else if (op[4:1] == OP_SB)     cls = C_SB;
    else if (op[4:1] == OP_JMPADR) cls = C_JMPADR;
    else if (op == OP_JMPI)        cls = C_JMPI;
    else if (op >= OP_BR_BASE)     cls = C_BR;
    else                           cls = C_ALU;
    return cls;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Single-port memory handshake shared between instruction fetch and lb/sb access.
interface cpu_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic              mem_addr_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns IR, steps FETCH/DECODE/EXEC/MEM/WB,
// arbitrates the memory port and emits one-cycle commit strobes.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                branch_taken,
  cpu_sequencer_if.master     mem,
  output logic [DATA_W-1:0]   ir,
  output logic                rf_commit,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                busy,
  output logic [RETIRE_W-1:0] retire_cnt
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                br_q, br_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_addr_sel_q, mem_addr_sel_d;
  logic                rf_commit_q, rf_commit_d;
  logic                pc_inc_q, pc_inc_d;
  logic                pc_load_q, pc_load_d;
  logic                busy_q, busy_d;
  op_class_e           cls_d;

  // Next state plus next-cycle outputs; outputs are precomputed from the
  // next state so every output leaves a flop and nothing combinational
  // reaches a port from mem_ack or branch_taken.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    br_d     = br_q;
    retire_d = retire_q;

    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        br_d    = branch_taken;
        state_d = (op_class(ir_q[DATA_W-1 -: 5]) inside {C_LB, C_SB}) ? S_MEM : S_WB;
      end
      S_MEM:    if (mem.mem_ack) state_d = S_WB;
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d == S_WB) retire_d = retire_q + RETIRE_W'(1);

    cls_d          = op_class(ir_d[DATA_W-1 -: 5]);
    mem_req_d      = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_addr_sel_d = (state_d == S_MEM);
    mem_we_d       = (state_d == S_MEM) && (cls_d == C_SB);
    busy_d         = (state_d != S_IDLE);
    pc_load_d      = (state_d == S_WB) &&
                     ((cls_d == C_JMPADR) || (cls_d == C_JMPI) || ((cls_d == C_BR) && br_d));
    pc_inc_d       = (state_d == S_WB) && !pc_load_d;
    rf_commit_d    = (state_d == S_WB) &&
                     !(cls_d inside {C_SB, C_JMPADR, C_JMPI, C_BR});
  end

  // Sequencer state, IR, branch flag, retire counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ir_q           <= '0;
      br_q           <= 1'b0;
      retire_q       <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      rf_commit_q    <= 1'b0;
      pc_inc_q       <= 1'b0;
      pc_load_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ir_q           <= ir_d;
      br_q           <= br_d;
      retire_q       <= retire_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_sel_q <= mem_addr_sel_d;
      rf_commit_q    <= rf_commit_d;
      pc_inc_q       <= pc_inc_d;
      pc_load_q      <= pc_load_d;
      busy_q         <= busy_d;
    end
  end

  assign mem.mem_req      = mem_req_q;
  assign mem.mem_we       = mem_we_q;
  assign mem.mem_addr_sel = mem_addr_sel_q;
  assign ir               = ir_q;
  assign rf_commit        = rf_commit_q;
  assign pc_inc           = pc_inc_q;
  assign pc_load          = pc_load_q;
  assign busy             = busy_q;
  assign retire_cnt       = retire_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: main instance (RETIRE_W=16) plus a
// narrow-counter instance used to reach the retire counter wrap quickly.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        bt;
  logic [7:0]  ir;
  logic        rf_commit, pc_inc, pc_load, busy;
  logic [15:0] retire_cnt;

  logic        run_w;
  logic [7:0]  ir_w;
  logic        rf_commit_w, pc_inc_w, pc_load_w, busy_w;
  logic [3:0]  retire_w;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.DATA_W(8)) m ();
  cpu_sequencer_if #(.DATA_W(8)) w ();

  assign w.mem_ack   = 1'b1;
  assign w.mem_rdata = 8'h00;

  cpu_sequencer #(.DATA_W(8), .RETIRE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .branch_taken(bt), .mem(m.master),
    .ir(ir), .rf_commit(rf_commit), .pc_inc(pc_inc), .pc_load(pc_load),
    .busy(busy), .retire_cnt(retire_cnt)
  );

  cpu_sequencer #(.DATA_W(8), .RETIRE_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w), .branch_taken(1'b0), .mem(w.master),
    .ir(ir_w), .rf_commit(rf_commit_w), .pc_inc(pc_inc_w), .pc_load(pc_load_w),
    .busy(busy_w), .retire_cnt(retire_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; run_w = 1'b0; bt = 1'b0;
    m.mem_ack = 1'b0; m.mem_rdata = 8'h00;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_req", m.mem_req, 0);
    chk("rst_ir", ir, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_strobes", {rf_commit, pc_inc, pc_load}, 0);

    // ALU add, zero-wait memory
    rst_n = 1'b1; run = 1'b1; m.mem_ack = 1'b1; m.mem_rdata = 8'h03;
    tick();
    chk("alu_fetch_req", m.mem_req, 1);
    chk("alu_fetch_sel", m.mem_addr_sel, 0);
    chk("alu_fetch_we", m.mem_we, 0);
    chk("alu_fetch_busy", busy, 1);
    tick();
    chk("alu_ir", ir, 8'h03);
    chk("alu_dec_req", m.mem_req, 0);
    tick();
    chk("alu_exec_commit", rf_commit, 0);
    tick();
    chk("alu_wb_commit", rf_commit, 1);
    chk("alu_wb_inc", pc_inc, 1);
    chk("alu_wb_load", pc_load, 0);
    chk("alu_retire", retire_cnt, 1);
    tick();
    chk("alu_refetch_req", m.mem_req, 1);
    chk("alu_refetch_strobes", {rf_commit, pc_inc}, 0);

    // sb with 3 wait states on the data access
    m.mem_rdata = 8'hA2;
    tick();
    chk("sb_ir", ir, 8'hA2);
    m.mem_ack = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sb_mem_req", m.mem_req, 1);
      chk("sb_mem_we", m.mem_we, 1);
      chk("sb_mem_sel", m.mem_addr_sel, 1);
    end
    m.mem_ack = 1'b1;
    tick();
    chk("sb_wb_inc", pc_inc, 1);
    chk("sb_wb_commit", rf_commit, 0);
    chk("sb_wb_load", pc_load, 0);
    chk("sb_wb_req", m.mem_req, 0);
    chk("sb_retire", retire_cnt, 2);

    // lb
    m.mem_rdata = 8'h91;
    tick();
    tick();
    chk("lb_ir", ir, 8'h91);
    tick();
    tick();
    chk("lb_mem_req", m.mem_req, 1);
    chk("lb_mem_we", m.mem_we, 0);
    chk("lb_mem_sel", m.mem_addr_sel, 1);
    tick();
    chk("lb_wb_commit", rf_commit, 1);
    chk("lb_wb_inc", pc_inc, 1);
    chk("lb_retire", retire_cnt, 3);

    // beq taken
    m.mem_rdata = 8'hD8;
    tick();
    tick();
    chk("beq_ir", ir, 8'hD8);
    bt = 1'b1;
    tick();
    tick();
    chk("beq_t_load", pc_load, 1);
    chk("beq_t_inc", pc_inc, 0);
    chk("beq_t_commit", rf_commit, 0);
    chk("beq_t_retire", retire_cnt, 4);
    bt = 1'b0;

    // beq not taken: flag high in DECODE only, low in EXEC
    tick();
    tick();
    bt = 1'b1;
    tick();
    bt = 1'b0;
    tick();
    chk("beq_nt_load", pc_load, 0);
    chk("beq_nt_inc", pc_inc, 1);
    chk("beq_nt_retire", retire_cnt, 5);

    // run dropped during DECODE
    m.mem_rdata = 8'h03;
    tick();
    tick();
    run = 1'b0;
    tick();
    chk("stop_exec_busy", busy, 1);
    tick();
    chk("stop_wb_commit", rf_commit, 1);
    chk("stop_retire", retire_cnt, 6);
    tick();
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_req", m.mem_req, 0);
    tick();
    chk("stop_hold_req", m.mem_req, 0);
    chk("stop_hold_busy", busy, 0);

    // reset asserted mid-MEM on an sb
    run = 1'b1; m.mem_rdata = 8'hA2; m.mem_ack = 1'b1;
    tick();
    tick();
    m.mem_ack = 1'b0;
    tick();
    tick();
    chk("mrst_pre_req", m.mem_req, 1);
    chk("mrst_pre_we", m.mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_req", m.mem_req, 0);
    chk("mrst_we_sel", {m.mem_we, m.mem_addr_sel}, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ir", ir, 0);
    chk("mrst_retire", retire_cnt, 0);
    chk("mrst_strobes", {rf_commit, pc_inc, pc_load}, 0);
    m.mem_ack = 1'b1;
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_req", m.mem_req, 0);
    chk("post_rst_ir", ir, 0);

    // retire counter wrap on the 4-bit instance, 4 cycles per ALU op
    run_w = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick(); tick(); tick(); tick();
      if (n == 15) chk("wrap_15", retire_w, 15);
      if (n == 16) begin
        chk("wrap_16", retire_w, 0);
        chk("wrap_inc", pc_inc_w, 1);
        chk("wrap_commit", rf_commit_w, 1);
        chk("wrap_load", pc_load_w, 0);
        chk("wrap_busy", busy_w, 1);
        chk("wrap_ir", ir_w, 0);
      end
      if (n == 17) chk("wrap_17", retire_w, 1);
    end
    run_w = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
